// File: rtl/ucsbece154b_perf_monitor_if.sv
// Bus between the pipeline and the performance monitor: event inputs, snapshot/read control,
// and the shadow/status read-back.
interface ucsbece154b_perf_monitor_if #(
    parameter int unsigned WIDTH = 32
);
    logic             enable_i;
    logic             clear_i;
    logic             stall_f_i;
    logic             resolve_e_i;
    logic             is_branch_e_i;
    logic             is_jump_e_i;
    logic             pred_taken_e_i;
    logic             actual_taken_e_i;
    logic             snapshot_i;
    logic [2:0]       rd_sel_i;
    logic [WIDTH-1:0] rd_data_o;
    logic [5:0]       overflow_o;
    logic             snap_valid_o;

    modport master (
        output enable_i, clear_i, stall_f_i, resolve_e_i, is_branch_e_i, is_jump_e_i,
               pred_taken_e_i, actual_taken_e_i, snapshot_i, rd_sel_i,
        input  rd_data_o, overflow_o, snap_valid_o
    );

    modport slave (
        input  enable_i, clear_i, stall_f_i, resolve_e_i, is_branch_e_i, is_jump_e_i,
               pred_taken_e_i, actual_taken_e_i, snapshot_i, rd_sel_i,
        output rd_data_o, overflow_o, snap_valid_o
    );
endinterface

// File: rtl/ucsbece154b_perf_monitor.sv
// Six pipeline event counters (cycles, instructions, branches, branch mispredicts, jumps,
// jump mispredicts) with sticky overflow flags and a snapshot shadow bank for read-back.
module ucsbece154b_perf_monitor #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          SATURATE = 1'b1
) (
    input logic                    clk,
    input logic                    reset,
    ucsbece154b_perf_monitor_if.slave bus
);
    localparam logic [WIDTH-1:0] Ones = '1;
    localparam logic [WIDTH-1:0] One  = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q    [6];
    logic [WIDTH-1:0] cnt_d    [6];
    logic [WIDTH-1:0] shadow_q [6];
    logic [5:0]       ovf_q, ovf_d;
    logic [5:0]       inc;
    logic             snap_valid_q;
    logic [WIDTH-1:0] status;

    // Jump classification wins when both type flags are set.
    always_comb begin
        inc = '0;
        if (bus.enable_i) begin
            inc[0] = 1'b1;
            inc[1] = !bus.stall_f_i;
            if (bus.resolve_e_i) begin
                if (bus.is_jump_e_i) begin
                    inc[4] = 1'b1;
                    inc[5] = bus.pred_taken_e_i != bus.actual_taken_e_i;
                end else if (bus.is_branch_e_i) begin
                    inc[2] = 1'b1;
                    inc[3] = bus.pred_taken_e_i != bus.actual_taken_e_i;
                end
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < 6; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.clear_i) begin
                cnt_d[i] = '0;
            end else if (inc[i]) begin
                if (cnt_q[i] == Ones) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = SATURATE ? Ones : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + One;
                end
            end
        end
        if (bus.clear_i) ovf_d = '0;
    end

    // Shadows take the pre-edge live values, so a same-cycle clear is not seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
            ovf_q        <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (bus.snapshot_i) shadow_q[i] <= cnt_q[i];
            end
            ovf_q <= ovf_d;
            if (bus.snapshot_i) snap_valid_q <= 1'b1;
        end
    end

    always_comb begin
        status      = '0;
        status[6:0] = {snap_valid_q, ovf_q};
        unique case (bus.rd_sel_i)
            3'd0:    bus.rd_data_o = shadow_q[0];
            3'd1:    bus.rd_data_o = shadow_q[1];
            3'd2:    bus.rd_data_o = shadow_q[2];
            3'd3:    bus.rd_data_o = shadow_q[3];
            3'd4:    bus.rd_data_o = shadow_q[4];
            3'd5:    bus.rd_data_o = shadow_q[5];
            3'd6:    bus.rd_data_o = status;
            default: bus.rd_data_o = '0;
        endcase
    end

    assign bus.overflow_o   = ovf_q;
    assign bus.snap_valid_o = snap_valid_q;
endmodule

// File: tb/tb_ucsbece154b_perf_monitor.sv
// Directed bench: one task per scenario on a 32-bit saturating monitor, plus two 8-bit
// monitors (saturating and wrapping) for the overflow boundary.
module tb_ucsbece154b_perf_monitor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #10 clk = ~clk;

    ucsbece154b_perf_monitor_if #(.WIDTH(32)) bus ();
    ucsbece154b_perf_monitor_if #(.WIDTH(8))  bus8s ();
    ucsbece154b_perf_monitor_if #(.WIDTH(8))  bus8w ();

    ucsbece154b_perf_monitor #(.WIDTH(32), .SATURATE(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    ucsbece154b_perf_monitor #(.WIDTH(8), .SATURATE(1'b1)) dut8s (
        .clk(clk), .reset(reset), .bus(bus8s)
    );
    ucsbece154b_perf_monitor #(.WIDTH(8), .SATURATE(1'b0)) dut8w (
        .clk(clk), .reset(reset), .bus(bus8w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.enable_i = 0; bus.clear_i = 0; bus.stall_f_i = 0; bus.resolve_e_i = 0;
        bus.is_branch_e_i = 0; bus.is_jump_e_i = 0; bus.pred_taken_e_i = 0;
        bus.actual_taken_e_i = 0; bus.snapshot_i = 0; bus.rd_sel_i = 0;
        bus8s.enable_i = 0; bus8s.clear_i = 0; bus8s.stall_f_i = 0; bus8s.resolve_e_i = 0;
        bus8s.is_branch_e_i = 0; bus8s.is_jump_e_i = 0; bus8s.pred_taken_e_i = 0;
        bus8s.actual_taken_e_i = 0; bus8s.snapshot_i = 0; bus8s.rd_sel_i = 0;
        bus8w.enable_i = 0; bus8w.clear_i = 0; bus8w.stall_f_i = 0; bus8w.resolve_e_i = 0;
        bus8w.is_branch_e_i = 0; bus8w.is_jump_e_i = 0; bus8w.pred_taken_e_i = 0;
        bus8w.actual_taken_e_i = 0; bus8w.snapshot_i = 0; bus8w.rd_sel_i = 0;
    endtask

    task automatic take_snapshot();
        bus.enable_i   = 0;
        bus.snapshot_i = 1;
        tick();
        bus.snapshot_i = 0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.rd_sel_i = 3'(i);
            #1;
            n_cmp++;
            if (bus.rd_data_o !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_rd sel%0d: got %0d want 0", i, bus.rd_data_o);
            end
        end
        n_cmp++;
        if (bus.overflow_o !== 6'd0 || bus.snap_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got ovf=%b sv=%b want 000000/0",
                     bus.overflow_o, bus.snap_valid_o);
        end
    endtask

    task automatic test_basic_count();
        logic [9:0] pat = 10'b0010010010;
        logic [31:0] exp [8];
        reset = 0;
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.enable_i  = 1;
            bus.stall_f_i = pat[i];
            tick();
        end
        bus.stall_f_i = 0;
        take_snapshot();
        exp = '{32'd10, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'h40, 32'd0};
        for (int i = 0; i < 8; i++) begin
            bus.rd_sel_i = 3'(i);
            #1;
            n_cmp++;
            if (bus.rd_data_o !== exp[i]) begin
                n_bad++;
                $display("FAIL basic sel%0d: got %0d want %0d", i, bus.rd_data_o, exp[i]);
            end
        end
        n_cmp++;
        if (bus.overflow_o !== 6'd0 || bus.snap_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_flags: got ovf=%b sv=%b want 000000/1",
                     bus.overflow_o, bus.snap_valid_o);
        end
    endtask

    // Vectors: {resolve, is_jump, is_branch, pred, actual}
    task automatic test_prediction();
        logic [4:0] vec [10];
        logic [31:0] exp [6];
        vec = '{5'b10111, 5'b10100, 5'b10110, 5'b10100,   // branches, 1 mispredict
                5'b11011, 5'b11010, 5'b11001,             // jumps, 2 mispredicts
                5'b11111,                                 // both flags: counts as jump
                5'b10011,                                 // no type: nothing
                5'b00110};                                // no resolve: nothing
        bus.clear_i = 1;
        tick();
        bus.clear_i   = 0;
        bus.stall_f_i = 1;
        for (int i = 0; i < 10; i++) begin
            bus.enable_i = 1;
            {bus.resolve_e_i, bus.is_jump_e_i, bus.is_branch_e_i,
             bus.pred_taken_e_i, bus.actual_taken_e_i} = vec[i];
            tick();
        end
        {bus.resolve_e_i, bus.is_jump_e_i, bus.is_branch_e_i,
         bus.pred_taken_e_i, bus.actual_taken_e_i} = 5'b0;
        bus.stall_f_i = 0;
        take_snapshot();
        exp = '{32'd10, 32'd0, 32'd4, 32'd1, 32'd4, 32'd2};
        for (int i = 0; i < 6; i++) begin
            bus.rd_sel_i = 3'(i);
            #1;
            n_cmp++;
            if (bus.rd_data_o !== exp[i]) begin
                n_bad++;
                $display("FAIL predict sel%0d: got %0d want %0d", i, bus.rd_data_o, exp[i]);
            end
        end
    endtask

    task automatic test_enable_gating();
        logic [31:0] exp [6];
        for (int i = 0; i < 5; i++) begin
            bus.enable_i         = 0;
            bus.stall_f_i        = 0;
            bus.resolve_e_i      = 1;
            bus.is_jump_e_i      = i[0];
            bus.is_branch_e_i    = !i[0];
            bus.pred_taken_e_i   = 1;
            bus.actual_taken_e_i = 0;
            tick();
        end
        {bus.resolve_e_i, bus.is_jump_e_i, bus.is_branch_e_i,
         bus.pred_taken_e_i, bus.actual_taken_e_i} = 5'b0;
        take_snapshot();
        exp = '{32'd10, 32'd0, 32'd4, 32'd1, 32'd4, 32'd2};
        for (int i = 0; i < 6; i++) begin
            bus.rd_sel_i = 3'(i);
            #1;
            n_cmp++;
            if (bus.rd_data_o !== exp[i]) begin
                n_bad++;
                $display("FAIL gating sel%0d: got %0d want %0d", i, bus.rd_data_o, exp[i]);
            end
        end
    endtask

    task automatic test_clear_snapshot();
        bus.clear_i = 1;
        tick();
        bus.clear_i = 0;
        for (int i = 0; i < 20; i++) begin
            bus.enable_i = 1;
            tick();
        end
        bus.clear_i    = 1;
        bus.snapshot_i = 1;
        tick();
        bus.clear_i    = 0;
        bus.snapshot_i = 0;
        bus.enable_i   = 0;
        bus.rd_sel_i   = 3'd0;
        #1;
        n_cmp++;
        if (bus.rd_data_o !== 32'd20) begin
            n_bad++;
            $display("FAIL clrsnap_shadow0: got %0d want 20", bus.rd_data_o);
        end
        n_cmp++;
        if (bus.overflow_o !== 6'd0 || bus.snap_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL clrsnap_flags: got ovf=%b sv=%b want 000000/1",
                     bus.overflow_o, bus.snap_valid_o);
        end
        take_snapshot();
        bus.rd_sel_i = 3'd0;
        #1;
        n_cmp++;
        if (bus.rd_data_o !== 32'd0) begin
            n_bad++;
            $display("FAIL clrsnap_live0: got %0d want 0", bus.rd_data_o);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            bus.enable_i = 1;
            tick();
        end
        bus.snapshot_i = 1;
        tick();
        bus.snapshot_i = 0;
        #5;
        reset = 1;
        #1;
        n_cmp++;
        if (bus.overflow_o !== 6'd0 || bus.snap_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_flags: got ovf=%b sv=%b want 000000/0",
                     bus.overflow_o, bus.snap_valid_o);
        end
        for (int i = 0; i < 8; i++) begin
            bus.rd_sel_i = 3'(i);
            #1;
            n_cmp++;
            if (bus.rd_data_o !== 32'd0) begin
                n_bad++;
                $display("FAIL areset_rd sel%0d: got %0d want 0", i, bus.rd_data_o);
            end
        end
        reset = 0;
        tick();
        take_snapshot();
        bus.rd_sel_i = 3'd0;
        #1;
        n_cmp++;
        if (bus.rd_data_o !== 32'd1) begin
            n_bad++;
            $display("FAIL areset_restart: got %0d want 1", bus.rd_data_o);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 255; i++) begin
            bus8s.enable_i = 1;
            bus8w.enable_i = 1;
            tick();
        end
        n_cmp++;
        if (bus8s.overflow_o !== 6'd0 || bus8w.overflow_o !== 6'd0) begin
            n_bad++;
            $display("FAIL sat_at_ones: got ovf_s=%b ovf_w=%b want 000000",
                     bus8s.overflow_o, bus8w.overflow_o);
        end
        tick();
        n_cmp++;
        if (bus8s.overflow_o !== 6'b000011 || bus8w.overflow_o !== 6'b000011) begin
            n_bad++;
            $display("FAIL sat_first_wrap: got ovf_s=%b ovf_w=%b want 000011",
                     bus8s.overflow_o, bus8w.overflow_o);
        end
        for (int i = 0; i < 44; i++) tick();
        bus8s.enable_i   = 0;
        bus8w.enable_i   = 0;
        bus8s.snapshot_i = 1;
        bus8w.snapshot_i = 1;
        tick();
        bus8s.snapshot_i = 0;
        bus8w.snapshot_i = 0;
        bus8s.rd_sel_i   = 3'd0;
        bus8w.rd_sel_i   = 3'd0;
        #1;
        n_cmp++;
        if (bus8s.rd_data_o !== 8'd255) begin
            n_bad++;
            $display("FAIL sat_hold: got %0d want 255", bus8s.rd_data_o);
        end
        n_cmp++;
        if (bus8w.rd_data_o !== 8'd44) begin
            n_bad++;
            $display("FAIL sat_wrap: got %0d want 44", bus8w.rd_data_o);
        end
        bus8s.rd_sel_i = 3'd6;
        #1;
        n_cmp++;
        if (bus8s.rd_data_o !== 8'h43) begin
            n_bad++;
            $display("FAIL sat_status: got %h want 43", bus8s.rd_data_o);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_basic_count();
        test_prediction();
        test_enable_gating();
        test_clear_snapshot();
        test_async_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
